// File: rtl/seqdet_rr_sched_pkg.sv
// Shared types and constants for the round-robin serial 1010 detector scheduler.
package seqdet_rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } det_state_t;

    localparam logic [3:0] PATTERN = 4'b1010;

    // Overlapping detector advance; a completed match falls back to the "10" prefix.
    function automatic det_state_t det_next(input det_state_t s, input logic b);
        case (s)
            S0:      det_next = (b == PATTERN[3]) ? S1   : S0;
            S1:      det_next = (b == PATTERN[2]) ? S10  : S1;
            S10:     det_next = (b == PATTERN[1]) ? S101 : S0;
            default: det_next = (b == PATTERN[0]) ? S10  : S1;
        endcase
    endfunction

endpackage

// File: rtl/seqdet_1010_core.sv
// Mealy 1010 detector: hit is combinational on the bit that completes the pattern.
module seqdet_1010_core
    import seqdet_rr_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    det_state_t st_q;
    det_state_t st_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= S0;
        end else begin
            st_q <= st_d;
        end
    end

    // Clear has priority so a frame's tail never leaks into the next one.
    always_comb begin
        st_d = st_q;
        if (clr) begin
            st_d = S0;
        end else if (en) begin
            st_d = det_next(st_q, bit_in);
        end
    end

    assign hit = (st_q == S101) && en && (bit_in == PATTERN[0]);

endmodule

// File: rtl/seqdet_rr_sched.sv
// Round-robin arbiter over NREQ serial channels feeding one 1010 detector with per-frame match count.
// Optional idle-bit timeout abort is enabled by defining SEQSCHED_TIMEOUT_EN.
module seqdet_rr_sched
    import seqdet_rr_sched_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TO_CYC = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          bit_in,
    input  logic [NREQ-1:0]          bit_vld,
    input  logic [NREQ-1:0]          last,
    output logic [NREQ-1:0]          gnt,
    output logic                     match,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_ch,
    output logic [CNT_W-1:0]         done_count,
    output logic                     abort
);

    localparam int unsigned CH_W = $clog2(NREQ);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [CH_W-1:0]  ch_q;
    logic [CH_W-1:0]  ch_d;
    logic [CH_W-1:0]  last_served_q;
    logic [CH_W-1:0]  last_served_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_sat;

    logic [NREQ-1:0]  gnt_d;
    logic             match_d;
    logic             done_d;
    logic [CH_W-1:0]  done_ch_d;
    logic [CNT_W-1:0] done_count_d;
    logic             abort_d;

    logic [CH_W-1:0]  rr_idx;
    logic [CH_W-1:0]  rr_cand;
    logic             rr_found;

    logic             in_grant;
    logic             acc;
    logic             acc_last;
    logic             req_drop;
    logic             to_expire;
    logic             abort_cond;
    logic             det_clr;
    logic             det_hit;

    assign in_grant   = (state_q == ST_GRANT);
    assign acc        = in_grant && gnt[ch_q] && bit_vld[ch_q];
    assign acc_last   = acc && last[ch_q];
    assign req_drop   = in_grant && !req[ch_q];
    // An accepted last bit outranks a simultaneous request drop or timeout.
    assign abort_cond = in_grant && !acc_last && (req_drop || to_expire);
    assign det_clr    = !in_grant || abort_cond;
    assign cnt_sat    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    seqdet_1010_core u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (det_clr),
        .en     (acc),
        .bit_in (bit_in[ch_q]),
        .hit    (det_hit)
    );

`ifdef SEQSCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Counts consecutive granted cycles without an accepted bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (!in_grant || acc) begin
            to_cnt_q <= '0;
        end else if (!to_expire) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign to_expire = in_grant && !acc && (to_cnt_q == TO_W'(TO_CYC - 1));
`else
    assign to_expire = 1'b0;
`endif

    // First requester at or after last_served+1, wrapping.
    always_comb begin
        rr_idx   = '0;
        rr_cand  = '0;
        rr_found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_cand = CH_W'((32'(last_served_q) + 32'd1 + i) % NREQ);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (acc_last) begin
                    state_d = ST_DONE;
                end else if (abort_cond) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d         = gnt;
        match_d       = det_hit;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        done_ch_d     = done_ch;
        done_count_d  = done_count;
        ch_d          = ch_q;
        last_served_d = last_served_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                gnt_d = '0;
                if (|req) begin
                    gnt_d = NREQ'(1) << rr_idx;
                    ch_d  = rr_idx;
                end
            end
            ST_GRANT: begin
                if (det_hit) begin
                    cnt_d = cnt_sat;
                end
                if (acc_last) begin
                    gnt_d         = '0;
                    done_d        = 1'b1;
                    done_ch_d     = ch_q;
                    done_count_d  = cnt_d;
                    last_served_d = ch_q;
                end else if (abort_cond) begin
                    gnt_d         = '0;
                    abort_d       = 1'b1;
                    done_ch_d     = ch_q;
                    last_served_d = ch_q;
                    cnt_d         = '0;
                end
            end
            default: begin
                gnt_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt           <= '0;
            match         <= 1'b0;
            done          <= 1'b0;
            abort         <= 1'b0;
            done_ch       <= '0;
            done_count    <= '0;
            ch_q          <= '0;
            last_served_q <= CH_W'(NREQ - 1);
            cnt_q         <= '0;
        end else begin
            gnt           <= gnt_d;
            match         <= match_d;
            done          <= done_d;
            abort         <= abort_d;
            done_ch       <= done_ch_d;
            done_count    <= done_count_d;
            ch_q          <= ch_d;
            last_served_q <= last_served_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Directed bench for seqdet_rr_sched (default instance plus a CNT_W=2 instance for saturation).
module tb_seqdet_rr_sched;

    logic       clk;
    logic       reset;
    logic [3:0] req, bit_in, bit_vld, last;
    logic [3:0] gnt;
    logic       match, done, abort;
    logic [1:0] done_ch;
    logic [7:0] done_count;

    logic [3:0] req2, bit_in2, bit_vld2, last2;
    logic [3:0] gnt2;
    logic       match2, done2, abort2;
    logic [1:0] done_ch2;
    logic [1:0] done_count2;

    int n_chk;
    int n_fail;
    int m2cnt;
    int gseq[5];

    seqdet_rr_sched #(.NREQ(4), .CNT_W(8), .TO_CYC(16)) dut (
        .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .bit_vld(bit_vld),
        .last(last), .gnt(gnt), .match(match), .done(done), .done_ch(done_ch),
        .done_count(done_count), .abort(abort)
    );

    seqdet_rr_sched #(.NREQ(4), .CNT_W(2), .TO_CYC(16)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .bit_in(bit_in2), .bit_vld(bit_vld2),
        .last(last2), .gnt(gnt2), .match(match2), .done(done2), .done_ch(done_ch2),
        .done_count(done_count2), .abort(abort2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ch, input logic b, input logic l);
        bit_in[ch]  = b;
        bit_vld[ch] = 1'b1;
        last[ch]    = l;
        tick();
        bit_in  = '0;
        bit_vld = '0;
        last    = '0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req      = '0; bit_in  = '0; bit_vld  = '0; last  = '0;
        req2     = '0; bit_in2 = '0; bit_vld2 = '0; last2 = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        gseq   = '{0, 1, 2, 3, 0};
        do_reset();

        // Reset values
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_match", 32'(match), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_abort", 32'(abort), 32'h0);
        check("rst_done_ch", 32'(done_ch), 32'h0);
        check("rst_done_count", 32'(done_count), 32'h0);

        // Ch0 frame 101010, matches after bits 4 and 6
        req = 4'b0001;
        tick();
        check("f1_gnt", 32'(gnt), 32'h1);
        send(0, 1'b1, 1'b0); check("f1_m1", 32'(match), 32'h0);
        send(0, 1'b0, 1'b0); check("f1_m2", 32'(match), 32'h0);
        send(0, 1'b1, 1'b0); check("f1_m3", 32'(match), 32'h0);
        send(0, 1'b0, 1'b0); check("f1_m4", 32'(match), 32'h1);
        send(0, 1'b1, 1'b0); check("f1_m5", 32'(match), 32'h0);
        send(0, 1'b0, 1'b1); check("f1_m6", 32'(match), 32'h1);
        check("f1_done", 32'(done), 32'h1);
        check("f1_done_ch", 32'(done_ch), 32'h0);
        check("f1_done_count", 32'(done_count), 32'h2);
        check("f1_gnt_off", 32'(gnt), 32'h0);
        req = '0;
        tick();
        check("f1_done_pulse", 32'(done), 32'h0);

        // All requesting: rotation 0,1,2,3,0, grant two cycles after done
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << gseq[g]));
            for (int k = 0; k < 4; k++) begin
                bit_vld = 4'b1111;
                bit_in  = (k < 2) ? 4'b1111 : 4'b0000;
                last    = (k == 3) ? (4'b0001 << gseq[g]) : ~(4'b0001 << gseq[g]);
                tick();
            end
            bit_vld = '0; bit_in = '0; last = '0;
            check("rr_done", 32'(done), 32'h1);
            check("rr_done_ch", 32'(done_ch), 32'(gseq[g]));
            check("rr_done_count", 32'(done_count), 32'h0);
            tick();
            check("rr_gap_gnt", 32'(gnt), 32'h0);
            tick();
        end
        req = '0;

        // Ch2 abort after 101, then a fresh frame starting 0 must not match
        do_reset();
        req = 4'b0100;
        tick();
        check("ab_gnt", 32'(gnt), 32'h4);
        send(2, 1'b1, 1'b0);
        send(2, 1'b0, 1'b0);
        send(2, 1'b1, 1'b0);
        req = '0;
        tick();
        check("ab_abort", 32'(abort), 32'h1);
        check("ab_done", 32'(done), 32'h0);
        check("ab_done_ch", 32'(done_ch), 32'h2);
        check("ab_gnt_off", 32'(gnt), 32'h0);
        tick();
        check("ab_abort_pulse", 32'(abort), 32'h0);
        req = 4'b0100;
        tick();
        check("ab_regnt", 32'(gnt), 32'h4);
        send(2, 1'b0, 1'b0); check("ab_nomatch", 32'(match), 32'h0);
        send(2, 1'b1, 1'b0);
        send(2, 1'b0, 1'b1);
        check("ab_nomatch2", 32'(match), 32'h0);
        check("ab_done2", 32'(done), 32'h1);
        check("ab_count2", 32'(done_count), 32'h0);
        req = '0;

        // CNT_W=2 saturation: eight repeats of 10
        do_reset();
        req2  = 4'b0001;
        m2cnt = 0;
        tick();
        check("sat_gnt", 32'(gnt2), 32'h1);
        for (int i = 0; i < 16; i++) begin
            bit_vld2 = 4'b0001;
            bit_in2  = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            last2    = (i == 15) ? 4'b0001 : 4'b0000;
            tick();
            m2cnt += int'(match2);
        end
        bit_vld2 = '0; bit_in2 = '0; last2 = '0; req2 = '0;
        check("sat_done", 32'(done2), 32'h1);
        check("sat_done_ch", 32'(done_ch2), 32'h0);
        check("sat_count", 32'(done_count2), 32'h3);
        check("sat_matches", 32'(m2cnt), 32'd7);
        check("sat_abort", 32'(abort2), 32'h0);

        // Ch1 stalls with bit_vld low
        do_reset();
        req = 4'b0010;
        tick();
        check("to_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 15; i++) tick();
        check("to_pre_abort", 32'(abort), 32'h0);
        check("to_pre_gnt", 32'(gnt), 32'h2);
        tick();
`ifdef SEQSCHED_TIMEOUT_EN
        check("to_abort", 32'(abort), 32'h1);
        check("to_done_ch", 32'(done_ch), 32'h1);
        check("to_gnt_off", 32'(gnt), 32'h0);
`else
        check("to_abort", 32'(abort), 32'h0);
        check("to_gnt_held", 32'(gnt), 32'h2);
`endif
        req = '0;
        tick();

        // Reset mid-frame on ch3, then lowest requester wins
        do_reset();
        req = 4'b1000;
        tick();
        check("rm_gnt", 32'(gnt), 32'h8);
        send(3, 1'b1, 1'b0);
        send(3, 1'b0, 1'b0);
        send(3, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("rm_gnt0", 32'(gnt), 32'h0);
        check("rm_match0", 32'(match), 32'h0);
        check("rm_done0", 32'(done), 32'h0);
        check("rm_abort0", 32'(abort), 32'h0);
        check("rm_done_ch0", 32'(done_ch), 32'h0);
        check("rm_done_count0", 32'(done_count), 32'h0);
        tick();
        reset = 1'b1;
        req   = 4'b1010;
        tick();
        check("rm_regnt", 32'(gnt), 32'h2);
        check("rm_no_done", 32'(done), 32'h0);
        check("rm_no_abort", 32'(abort), 32'h0);
        req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seqdet_rr_sched.md
SEQDET_RR_SCHED -- requirements
Module: seqdet_rr_sched

Interface
REQ-001 Parameter NREQ, default 4, number of serial requesters (2..8).
REQ-002 Parameter CNT_W, default 8, width of per-frame match counter.
REQ-003 Parameter TO_CYC, default 16, idle-bit timeout in cycles (used only with SEQSCHED_TIMEOUT_EN).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-channel request, held high for the whole frame.
REQ-007 bit_in  input  NREQ  per-channel serial data bit.
REQ-008 bit_vld  input  NREQ  per-channel bit qualifier.
REQ-009 last  input  NREQ  per-channel end-of-frame flag, qualified by bit_vld.
REQ-010 gnt  output  NREQ  registered one-hot grant, zero when idle.
REQ-011 match  output  1  registered one-cycle pulse per detected 1010.
REQ-012 done  output  1  registered one-cycle pulse at frame completion.
REQ-013 done_ch  output  clog2(NREQ)  channel index, valid with done or abort.
REQ-014 done_count  output  CNT_W  matches in the finished frame, valid with done.
REQ-015 abort  output  1  registered one-cycle pulse when a granted frame is abandoned.

Function
REQ-016 FSM states: IDLE, GRANT, DONE; reset state IDLE.
REQ-017 IDLE: if any req bit set, select the first set bit searching upward from (last_served+1) mod NREQ, load gnt one-hot, go GRANT; grant appears the cycle after req is seen.
REQ-018 GRANT: a bit is accepted only in a cycle with gnt[ch] and bit_vld[ch]; unselected channels' inputs are ignored.
REQ-019 Each accepted bit advances the detector core; pattern 1010, overlapping (after a match the detector continues from the "10" prefix state).
REQ-020 On an accepted bit completing 1010: match pulses the next cycle; frame counter increments, saturating at 2^CNT_W-1.
REQ-021 Accepted bit with last[ch]=1: that bit is still evaluated and counted; next cycle state DONE, gnt=0, done=1, done_ch=ch, done_count=final count; last_served=ch.
REQ-022 DONE lasts exactly one cycle then IDLE; detector cleared and counter zeroed on leaving DONE; minimum 2 cycles from done to next grant.
REQ-023 req[ch] falling while in GRANT (without an accepted last bit that cycle): next cycle gnt=0, abort=1, done_ch=ch, no done; last_served=ch; go IDLE, detector and counter cleared.
REQ-024 req drop and accepted last bit in the same cycle: last wins (done, no abort).
REQ-025 bit_vld on the granted channel with last=1 but req low: treated as last (REQ-024).
REQ-026 Detector state never carries across frames or channels.

Reset
REQ-027 Reset asserted: gnt=0, match=0, done=0, abort=0, done_ch=0, done_count=0, state IDLE, detector S0, counter 0, last_served=NREQ-1 (channel 0 wins first).
REQ-028 Reset mid-frame discards the frame with no done or abort pulse.

Configuration
REQ-029 Macro SEQSCHED_TIMEOUT_EN defined: in GRANT, TO_CYC consecutive cycles with no accepted bit trigger the REQ-023 abort path; any accepted bit reloads the timer.
REQ-030 Macro undefined: no timer logic; a granted channel may stall indefinitely.

Structure
REQ-031 Shared package holds the FSM state enum, the detector state enum (S0, S1, S10, S101) and the pattern constant 4'b1010.
REQ-032 Detector is a sub-module seqdet_1010_core: clk, reset, clr, en, bit_in, hit (Mealy, combinational hit = S101 and en and bit_in==0).

Verification
REQ-033 Ch0 frame 1,0,1,0,1,0 last on 6th -> match pulses after bits 4 and 6, done=1, done_ch=0, done_count=2.
REQ-034 req=4'b1111 held, each frame 4 bits -> grants in order 0,1,2,3,0, each done followed by a grant 2 cycles later.
REQ-035 Ch2 frame 1,0,1 then req[2] dropped -> abort=1, done_ch=2, no done, next frame on ch2 starting 0 yields no match.
REQ-036 CNT_W=2, frame of eight repeats of 10 -> done_count=3 (saturated).
REQ-037 SEQSCHED_TIMEOUT_EN, TO_CYC=16, ch1 granted, bit_vld low 16 cycles -> abort=1, done_ch=1; without macro, gnt[1] remains high.
REQ-038 Reset asserted mid-frame on ch3 -> all outputs 0 next edge, first subsequent grant goes to lowest requesting channel.
